// File: rtl/sobel_kernel_engine.sv
// Sobel 3x3 compute stage: per start pulse, fetches one window, emits sat(|Gx|+|Gy|).
// Ports: clk/rst, clear, start in; pix_addr/pix_rd/pix_data to image mem; g_data/g_addr/ready/done/busy out.
module sobel_kernel_engine #(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 6,
  parameter int GADDR_W = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               kernel_start_i,
  output logic [ADDR_W-1:0]  pix_addr_o,
  output logic               pix_rd_o,
  input  logic [PIX_W-1:0]   pix_data_i,
  output logic [PIX_W-1:0]   g_data_o,
  output logic [GADDR_W-1:0] g_addr_o,
  output logic               kernel_res_ready_o,
  output logic               image_processed_o,
  output logic               busy_o
);

  localparam int ACC_W = PIX_W + 4;
  localparam logic [ACC_W:0] GMAX =
    {{(ACC_W+1-PIX_W){1'b0}}, {PIX_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FINISH
  } state_t;

  state_t state, state_nx;

  logic [3:0]        cnt;
  logic [3:0]        tap_q;
  logic [3:0]        tap_d;
  logic              rd_d;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;

  logic signed [ACC_W-1:0] gx, gy;
  logic signed [ACC_W-1:0] gx_nx, gy_nx;
  logic signed [ACC_W-1:0] p1, p2;
  logic [ACC_W-1:0]        ax, ay;
  logic [ACC_W:0]          mag;
  logic [PIX_W-1:0]        gsat;

  logic [1:0]        tr, tc;
  logic [ADDR_W-1:0] row_t, col_t, tap_addr;
  logic              issue, last_acc, last_pos, go;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; clear wins over everything
  assign go = kernel_start_i && !image_processed_o;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (go) state_nx = FETCH;
      FETCH:   if (last_acc) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clear_i) state_nx = IDLE;
  end

  // Outputs decoded from state
  always_comb begin
    busy_o             = (state != IDLE);
    kernel_res_ready_o = (state == FINISH);
  end

  // Tap index -> (row, col) offset within the 3x3 window
  always_comb begin
    tr = '0;
    tc = '0;
    unique case (1'b1)
      (cnt >= 4'd6): begin
        tr = 2'd2;
        tc = 2'(cnt - 4'd6);
      end
      (cnt >= 4'd3 && cnt < 4'd6): begin
        tr = 2'd1;
        tc = 2'(cnt - 4'd3);
      end
      (cnt < 4'd3): begin
        tr = 2'd0;
        tc = 2'(cnt);
      end
      default: ;
    endcase
  end

  assign row_t    = row + ADDR_W'(tr) - ADDR_W'(1);
  assign col_t    = col + ADDR_W'(tc) - ADDR_W'(1);
  assign tap_addr = row_t * ADDR_W'(IMG_W) + col_t;
  assign issue    = (state == FETCH) && (cnt < 4'd9);

  // Per-tap Sobel coefficients applied to the arriving datum
  assign p1 = $signed({{(ACC_W-PIX_W){1'b0}}, pix_data_i});
  assign p2 = p1 <<< 1;

  always_comb begin
    gx_nx = gx;
    gy_nx = gy;
    if (rd_d) begin
      unique case (tap_d)
        4'd0: begin gx_nx = gx - p1; gy_nx = gy - p1; end
        4'd1: gy_nx = gy - p2;
        4'd2: begin gx_nx = gx + p1; gy_nx = gy - p1; end
        4'd3: gx_nx = gx - p2;
        4'd5: gx_nx = gx + p2;
        4'd6: begin gx_nx = gx - p1; gy_nx = gy + p1; end
        4'd7: gy_nx = gy + p2;
        4'd8: begin gx_nx = gx + p1; gy_nx = gy + p1; end
        default: ;
      endcase
    end
  end

  // Magnitude uses the post-accumulate values so the last tap
  // and the result register share one edge.
  always_comb begin
    ax   = gx_nx[ACC_W-1] ? -gx_nx : gx_nx;
    ay   = gy_nx[ACC_W-1] ? -gy_nx : gy_nx;
    mag  = {1'b0, ax} + {1'b0, ay};
    gsat = (mag > GMAX) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
  end

  assign last_acc = rd_d && (tap_d == 4'd8);
  assign last_pos = (row == ADDR_W'(IMG_H-2)) &&
                    (col == ADDR_W'(IMG_W-2));

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt               <= '0;
      tap_q             <= '0;
      tap_d             <= '0;
      rd_d              <= 1'b0;
      gx                <= '0;
      gy                <= '0;
      row               <= ADDR_W'(1);
      col               <= ADDR_W'(1);
      pix_rd_o          <= 1'b0;
      pix_addr_o        <= '0;
      g_data_o          <= '0;
      g_addr_o          <= '0;
      image_processed_o <= 1'b0;
    end else if (clear_i) begin
      cnt               <= '0;
      tap_q             <= '0;
      tap_d             <= '0;
      rd_d              <= 1'b0;
      gx                <= '0;
      gy                <= '0;
      row               <= ADDR_W'(1);
      col               <= ADDR_W'(1);
      pix_rd_o          <= 1'b0;
      pix_addr_o        <= '0;
      g_data_o          <= '0;
      g_addr_o          <= '0;
      image_processed_o <= 1'b0;
    end else begin
      pix_rd_o <= issue;
      if (issue) begin
        pix_addr_o <= tap_addr;
        tap_q      <= cnt;
        cnt        <= cnt + 4'd1;
      end
      rd_d  <= pix_rd_o;
      tap_d <= tap_q;
      if (rd_d) begin
        gx <= gx_nx;
        gy <= gy_nx;
      end
      if (last_acc) begin
        g_data_o <= gsat;
        g_addr_o <= GADDR_W'((row - ADDR_W'(1)) * ADDR_W'(IMG_W-2)
                             + (col - ADDR_W'(1)));
        if (last_pos) begin
          image_processed_o <= 1'b1;
        end else if (col == ADDR_W'(IMG_W-2)) begin
          col <= ADDR_W'(1);
          row <= row + ADDR_W'(1);
        end else begin
          col <= col + ADDR_W'(1);
        end
      end
      if (state == IDLE && state_nx == FETCH) begin
        cnt <= '0;
        gx  <= '0;
        gy  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_kernel_engine.sv
// Scoreboard bench for sobel_kernel_engine: directed images, timing,
// clear and reset cases; monitor pops expected results on each ready pulse.
module tb_sobel_kernel_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic [5:0] pix_addr;
  logic       pix_rd;
  logic [7:0] pix_data = '0;
  logic [7:0] g_data;
  logic [5:0] g_addr;
  logic       ready;
  logic       done;
  logic       busy;

  logic [7:0] img [64];

  typedef struct packed {
    logic [7:0] g;
    logic [5:0] a;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  logic imp;
  int   step_exp [6] = '{0, 0, 255, 255, 0, 0};

  sobel_kernel_engine dut (
    .clk_i              (clk),
    .rst_i              (rst_n),
    .clear_i            (clear),
    .kernel_start_i     (start),
    .pix_addr_o         (pix_addr),
    .pix_rd_o           (pix_rd),
    .pix_data_i         (pix_data),
    .g_data_o           (g_data),
    .g_addr_o           (g_addr),
    .kernel_res_ready_o (ready),
    .image_processed_o  (done),
    .busy_o             (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pix_rd) pix_data <= img[pix_addr];
  end

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: every ready pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && ready) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: got g=%0d addr=%0d, required none",
                 g_data, g_addr);
      end else begin
        e = q.pop_front();
        check("g_data", int'(g_data), int'(e.g));
        check("g_addr", int'(g_addr), int'(e.a));
      end
    end
  end

  task automatic fill(input int mode);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        case (mode)
          0: img[r*8+c] = 8'd100;
          1: img[r*8+c] = 8'(10*c);
          2: img[r*8+c] = 8'(10*r);
          default: img[r*8+c] = (c >= 4) ? 8'd200 : 8'd0;
        endcase
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic run_window(input int g, input int a, output logic d);
    logic seen;
    q.push_back({8'(g), 6'(a)});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    d = done;
    check("ready_seen", int'(seen), 1);
  endtask

  initial begin
    fill(0);
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_rd", int'(pix_rd), 0);
    check("rst_ready", int'(ready), 0);
    check("rst_done", int'(done), 0);
    check("rst_g", int'(g_data), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Flat image
    for (int i = 0; i < 36; i++) begin
      run_window(0, i, imp);
      if (i >= 34) check("done_edge", int'(imp), int'(i == 35));
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check("start_after_done_busy", int'(busy), 0);
    check("done_held", int'(done), 1);

    // Column ramp, row ramp, step
    do_clear();
    check("clear_done", int'(done), 0);
    fill(1);
    for (int i = 0; i < 36; i++) run_window(80, i, imp);
    do_clear();
    fill(2);
    for (int i = 0; i < 36; i++) run_window(80, i, imp);
    do_clear();
    fill(3);
    for (int i = 0; i < 36; i++) run_window(step_exp[i % 6], i, imp);

    // Latency and ignored second start
    do_clear();
    fill(0);
    q.push_back({8'd0, 6'd0});
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("rd_E+%0d", k), int'(pix_rd), int'(k <= 9));
      check($sformatf("ready_E+%0d", k), int'(ready), int'(k == 11));
      if (k == 3) start = 1'b1;
      if (k == 4) start = 1'b0;
    end
    repeat (15) @(negedge clk);

    // Mid-window clear
    do_clear();
    fill(1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    check("clear_busy", int'(busy), 0);
    check("clear_rd", int'(pix_rd), 0);
    repeat (15) @(negedge clk);
    run_window(80, 0, imp);

    // Mid-window async reset
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_rd", int'(pix_rd), 0);
    check("arst_ready", int'(ready), 0);
    check("arst_g", int'(g_data), 0);
    check("arst_addr", int'(pix_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_window(80, 0, imp);
    repeat (5) @(negedge clk);

    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
